// File: rtl/dotprod_pkg.sv
// Shared width helpers and the product typedef for the dotprod_stream datapath and its bench.
package dotprod_pkg;

  localparam int DEF_N_TAPS = 4;
  localparam int DEF_IN_W   = 8;
  localparam int DEF_COEF_W = 8;

  function automatic int calc_out_w(input int n_taps, input int in_w, input int coef_w);
    return in_w + coef_w + $clog2(n_taps);
  endfunction

  // A single-tap build still needs a 1-bit index port.
  function automatic int calc_idx_w(input int n_taps);
    return (n_taps > 1) ? $clog2(n_taps) : 1;
  endfunction

  localparam int DEF_OUT_W = calc_out_w(DEF_N_TAPS, DEF_IN_W, DEF_COEF_W);

  typedef logic signed [DEF_OUT_W-1:0] prod_t;

endpackage

// File: rtl/dotprod_adder_tree.sv
// Combinational balanced signed sum of N_OPS packed operands; built by recursive halving.
module dotprod_adder_tree #(
  parameter int N_OPS = 4,
  parameter int W     = 18
) (
  input  logic [N_OPS*W-1:0] i_ops,
  output logic signed [W-1:0] o_sum
);

  generate
    if (N_OPS == 1) begin : g_leaf
      assign o_sum = $signed(i_ops);
    end else begin : g_split
      localparam int N_LO = N_OPS / 2;
      localparam int N_HI = N_OPS - N_LO;
      logic signed [W-1:0] w_lo;
      logic signed [W-1:0] w_hi;

      dotprod_adder_tree #(.N_OPS(N_LO), .W(W)) u_lo (
        .i_ops (i_ops[N_LO*W-1:0]),
        .o_sum (w_lo)
      );

      dotprod_adder_tree #(.N_OPS(N_HI), .W(W)) u_hi (
        .i_ops (i_ops[N_OPS*W-1:N_LO*W]),
        .o_sum (w_hi)
      );

      assign o_sum = w_lo + w_hi;
    end
  endgenerate

endmodule

// File: rtl/dotprod_stream.sv
// Two-stage streaming signed dot product with a writable coefficient bank and valid/ready flow.
// Define DOTPROD_ACCUM_EN to add in_last and emit one accumulated result per frame.
module dotprod_stream
  import dotprod_pkg::*;
#(
  parameter int N_TAPS = 4,
  parameter int IN_W   = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = calc_out_w(N_TAPS, IN_W, COEF_W)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_TAPS*IN_W-1:0]        in_data,
`ifdef DOTPROD_ACCUM_EN
  input  logic                          in_last,
`endif
  input  logic                          coef_we,
  input  logic [calc_idx_w(N_TAPS)-1:0] coef_idx,
  input  logic signed [COEF_W-1:0]      coef_wdata,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [OUT_W-1:0]       out_data
);

  localparam int IDX_W  = calc_idx_w(N_TAPS);
  localparam int PROD_W = IN_W + COEF_W;

  logic signed [COEF_W-1:0] r_coef [N_TAPS];
  logic [N_TAPS*OUT_W-1:0]  w_prod;
  logic [N_TAPS*OUT_W-1:0]  r_s1_prod;
  logic                     r_s1_valid;
  logic                     r_s2_valid;
  logic signed [OUT_W-1:0]  r_s2_data;
  logic signed [OUT_W-1:0]  w_sum;
  logic                     w_adv;
`ifdef DOTPROD_ACCUM_EN
  logic                     r_s1_last;
  logic signed [OUT_W-1:0]  r_acc;
`endif

  generate
    for (genvar i = 0; i < N_TAPS; i++) begin : g_mul
      logic signed [PROD_W-1:0] w_p;
      assign w_p = PROD_W'($signed(in_data[i*IN_W +: IN_W])) * PROD_W'(r_coef[i]);
      assign w_prod[i*OUT_W +: OUT_W] = OUT_W'(w_p);
    end
  endgenerate

  dotprod_adder_tree #(.N_OPS(N_TAPS), .W(OUT_W)) u_tree (
    .i_ops (r_s1_prod),
    .o_sum (w_sum)
  );

  // Both stages move together; S2 only blocks when holding an unaccepted result.
  assign w_adv     = !r_s2_valid || out_ready;
  assign in_ready  = w_adv && !rst;
  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_TAPS; i++) r_coef[i] <= '0;
      r_s1_prod  <= '0;
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
`ifdef DOTPROD_ACCUM_EN
      r_s1_last  <= 1'b0;
      r_acc      <= '0;
`endif
    end else begin
      for (int i = 0; i < N_TAPS; i++) begin
        if (coef_we && coef_idx == IDX_W'(i)) r_coef[i] <= coef_wdata;
      end
      if (w_adv) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_prod <= w_prod;
`ifdef DOTPROD_ACCUM_EN
          r_s1_last <= in_last;
`endif
        end
`ifdef DOTPROD_ACCUM_EN
        if (r_s1_valid && r_s1_last) begin
          r_s2_data  <= r_acc + w_sum;
          r_acc      <= '0;
          r_s2_valid <= 1'b1;
        end else begin
          if (r_s1_valid) r_acc <= r_acc + w_sum;
          r_s2_valid <= 1'b0;
        end
`else
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) r_s2_data <= w_sum;
`endif
      end
    end
  end

endmodule

// File: tb/tb_dotprod_stream.sv
// Scoreboard bench for dotprod_stream: default 18-bit instance plus a 16-bit-output twin.
module tb_dotprod_stream;
  import dotprod_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        in_data;
  logic               coef_we;
  logic [1:0]         coef_idx;
  logic signed [7:0]  coef_wdata;
  logic               out_valid;
  logic               out_ready;
  logic signed [17:0] out_data;
  logic               in_ready16;
  logic               out_valid16;
  logic signed [15:0] out_data16;
`ifdef DOTPROD_ACCUM_EN
  logic               in_last;
`endif

  always #5 clk = ~clk;

  dotprod_stream dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef DOTPROD_ACCUM_EN
    .in_last(in_last),
`endif
    .coef_we(coef_we), .coef_idx(coef_idx), .coef_wdata(coef_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  dotprod_stream #(.OUT_W(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16), .in_data(in_data),
`ifdef DOTPROD_ACCUM_EN
    .in_last(in_last),
`endif
    .coef_we(coef_we), .coef_idx(coef_idx), .coef_wdata(coef_wdata),
    .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16)
  );

  typedef struct { int data; int d16; int cyc; } exp_t;
  exp_t q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_rcv    = 0;
  int tb_coef [4];
  int tb_acc   = 0;
  bit tb_last  = 1'b1;
  bit exact_lat = 1'b0;
  bit prev_stall = 1'b0;
  logic signed [17:0] prev_data;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  function automatic int w18(input int s);
    prod_t t;
    t = s[17:0];
    return int'(t);
  endfunction

  function automatic int w16(input int s);
    logic signed [15:0] t;
    t = s[15:0];
    return int'(t);
  endfunction

  function automatic int dot(input logic [31:0] d);
    int s = 0;
    for (int i = 0; i < 4; i++) begin
      logic signed [7:0] x;
      x = d[i*8 +: 8];
      s += int'(x) * tb_coef[i];
    end
    return s;
  endfunction

  task automatic push_exp(input int s);
    exp_t e;
    e.data = w18(s);
    e.d16  = w16(s);
    e.cyc  = cyc;
    q.push_back(e);
  endtask

  // One clock cycle: drive at negedge, score the output handshake, model the input handshake.
  task automatic cycle(input bit v, input logic [31:0] d, input bit ordy,
                       input bit we, input logic [1:0] idx, input int wd, output bit acc);
    exp_t e;
    int s;
    @(negedge clk);
    in_valid = v; in_data = d; out_ready = ordy;
    coef_we = we; coef_idx = idx; coef_wdata = wd[7:0];
`ifdef DOTPROD_ACCUM_EN
    in_last = tb_last;
`endif
    cyc++;
    #1;
    if (prev_stall) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, prev_data);
    end
    check("in_ready", in_ready, (!out_valid || out_ready));
    if (out_valid && out_ready) begin
      if (q.size() == 0) check("spurious_out", out_data, 32'sh7fffffff);
      else begin
        e = q.pop_front();
        n_rcv++;
        check("out_data", out_data, e.data);
        check("valid16", out_valid16, 1);
        check("out_data16", out_data16, e.d16);
        if (exact_lat) check("latency", cyc - e.cyc, 2);
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    acc = v && in_ready;
    if (acc) begin
      s = dot(d);
`ifdef DOTPROD_ACCUM_EN
      if (tb_last) begin
        push_exp(tb_acc + s);
        tb_acc = 0;
      end else tb_acc += s;
`else
      push_exp(s);
`endif
    end
    if (we) tb_coef[idx] = wd;
  endtask

  task automatic send(input logic [31:0] d);
    bit acc = 1'b0;
    for (int k = 0; k < 50 && !acc; k++) cycle(1'b1, d, 1'b1, 1'b0, 2'd0, 0, acc);
    check("send_timeout", acc, 1);
  endtask

  task automatic wcoef(input logic [1:0] idx, input int wd);
    bit acc;
    cycle(1'b0, 32'd0, 1'b1, 1'b1, idx, wd, acc);
  endtask

  task automatic drain();
    bit acc;
    for (int k = 0; k < 40 && q.size() > 0; k++) cycle(1'b0, 32'd0, 1'b1, 1'b0, 2'd0, 0, acc);
    check("drain_empty", q.size(), 0);
    repeat (3) cycle(1'b0, 32'd0, 1'b1, 1'b0, 2'd0, 0, acc);
  endtask

  initial begin
    bit acc;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int sent;
    int base;
    for (int i = 0; i < 4; i++) tb_coef[i] = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    coef_we = 1'b0; coef_idx = '0; coef_wdata = '0;
`ifdef DOTPROD_ACCUM_EN
    in_last = 1'b1;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 1'b0;

    // Coefficients at reset give zero.
    exact_lat = 1'b1;
    send(pack(1, 2, 3, 4));
    drain();

    // Write lands at the next edge; a coincident beat sees c3 still 0.
    wcoef(2'd0, -2); wcoef(2'd1, 1); wcoef(2'd2, 3);
    cycle(1'b1, pack(5, -3, 2, 7), 1'b1, 1'b1, 2'd3, -1, acc);
    check("coincident_accept", acc, 1);
    send(pack(5, -3, 2, 7));
    send(pack(-1, 4, -5, 2));
    drain();

    // Most negative corner: 65536 fits 18 bits, wraps to 0 in 16 bits.
    for (int i = 0; i < 4; i++) wcoef(i[1:0], -128);
    send(pack(-128, -128, -128, -128));
    send(pack(127, -128, 127, -128));
    drain();

    // Streaming under a 1,0,0,1 out_ready pattern.
    exact_lat = 1'b0;
    wcoef(2'd0, 3); wcoef(2'd1, -7); wcoef(2'd2, 55); wcoef(2'd3, -100);
    sent = 0;
    base = n_rcv;
    for (int k = 0; k < 200 && sent < 8; k++) begin
      cycle(1'b1, $urandom, pat[k % 4], 1'b0, 2'd0, 0, acc);
      if (acc) sent++;
    end
    check("stream_sent", sent, 8);
    drain();
    check("stream_count", n_rcv - base, 8);

    // Reset with two beats in flight.
    cycle(1'b1, pack(9, 9, 9, 9), 1'b0, 1'b0, 2'd0, 0, acc);
    cycle(1'b1, pack(8, 8, 8, 8), 1'b0, 1'b0, 2'd0, 0, acc);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    #1 check("rst_in_ready_mid", in_ready, 0);
    @(posedge clk); #1;
    check("rst_valid_mid", out_valid, 0);
    check("rst_data_mid", out_data, 0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    prev_stall = 1'b0;
    tb_acc = 0;
    for (int i = 0; i < 4; i++) tb_coef[i] = 0;
    exact_lat = 1'b1;
    send(pack(1, 2, 3, 4));
    drain();

`ifdef DOTPROD_ACCUM_EN
    // Frame of sums 10, -4, 7 gives 13; the next frame restarts from 0.
    wcoef(2'd0, 1);
    exact_lat = 1'b0;
    tb_last = 1'b0; send(pack(10, 0, 0, 0));
    send(pack(-4, 0, 0, 0));
    tb_last = 1'b1; send(pack(7, 0, 0, 0));
    drain();
    tb_last = 1'b0; send(pack(2, 0, 0, 0));
    tb_last = 1'b1; send(pack(3, 0, 0, 0));
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
